downsampler: RTL
================

# downsampler

Receive-side polyphase decimating matched filter, the counterpart of the transmit upsampler. It takes 18-bit 1s17 samples at the sample rate (sam_clk_ena) and runs the same 20-tap symmetric root/low-pass filter. It emits one filtered 1s17 value per symbol (sym_clk_ena), a 4:1 decimation. It sits between the channel front end and the symbol slicer.

## Interface
- N, 20, tap count; even, symmetric; N/2 MAC cycles per output
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sam_clk_ena  in  1  one-cycle strobe; x_in valid, shift into window
- sym_clk_ena  in  1  one-cycle strobe; start one decimated output computation
- x_in  in  18  signed 1s17 input sample
- y  out  18  signed 1s17 filtered, decimated output; held between updates
- y_valid  out  1  one-cycle pulse when y updates
- busy  out  1  high while a computation is in progress
- overrun_err  out  1  sticky; set when sym_clk_ena arrives while busy

## Operation
- Window: N×18 shift register w[0..N-1], w[0] newest.
  - On sam_clk_ena: w[0]<=x_in, w[k]<=w[k-1].
- FSM states: IDLE, LOAD, MAC, DONE.
  - IDLE: on sym_clk_ena go to LOAD.
  - LOAD: copy window into snapshot s[0..N-1]; clear acc; tap index k<=0.
  - MAC: acc <= acc + b[k]*(s[k]+s[N-1-k]) for k=0..N/2-1, one tap per cycle; leave after k=N/2-1.
  - DONE: y <= sat(acc); y_valid=1; go to IDLE.
- Snapshot sees the window after the trigger edge: if sam_clk_ena and sym_clk_ena coincide, that x_in is s[0].
- The window keeps shifting during MAC; the snapshot isolates the computation from it.
- sym_clk_ena while busy: ignored, overrun_err<=1. No restart and no y_valid for it.
- Coefficients b[0..9] = 599, 764, -30, -2078, -4101, -3432, 2323, 13046, 25177, 33269 (1s17, DC gain ≈1.0); b[19-k]=b[k].
- Arithmetic:
  - pre-add is 19-bit signed;
  - product is 37-bit signed (3s34);
  - acc is 40-bit signed.
- Output: y = acc[34:17] (floor truncation). If acc[39:34] is not all equal to the sign bit, saturate to +131071 or -131072.
- Reset (any state, including mid-MAC): window, snapshot, acc, k cleared to 0; state IDLE; y=0, y_valid=0, busy=0, overrun_err=0.

## Timing
- Trigger cycle T (sym_clk_ena high); LOAD at T+1; MAC at T+2..T+11; DONE/y_valid at T+12.
- Latency sym_clk_ena → y_valid: 12 clocks.
- busy high T+1..T+12 inclusive.
- Minimum sym_clk_ena spacing: 13 clocks. Nominal system has sam_clk_ena every 4 clocks and sym_clk_ena every 16 clocks, coincident with a sam_clk_ena.
- y changes only in the y_valid cycle; it holds its value otherwise.

## Structure
- Shared package:
  - coefficient constant array (10 unique taps, 18-bit signed);
  - N;
  - sample width 18, acc width 40, output slice constants;
  - FSM state enum.
- The same package feeds the upsampler's coefficient set, so both ends stay matched.
- One natural sub-module: `sym_mac`, the folded pre-add/multiply/accumulate datapath with saturation. It takes s pairs, b[k], clear/enable, and returns the saturated y. FSM, window and snapshot stay in the top level.

## Test plan
- Reset: hold reset 3 cycles with random strobes → y=0, y_valid=0, busy=0, overrun_err=0.
- Impulse:
  - Stimulus: x_in=65536 (0.5) on the sam_clk_ena coincident with sym_clk_ena, then zeros, sym_clk_ena every 4th sample.
  - Required: successive y = 299, -2051, 12588, 6523, -1039, then 0.
  - Each y appears 12 clocks after its sym_clk_ena.
- DC: x_in=65536 held for ≥20 samples → steady y=65537.
- Saturation:
  - x_in=131071 held → y=131071.
  - x_in=-131072 held → y=-131072 (unsaturated values would be 131073 and -131074).
- Overrun: two sym_clk_ena 5 clocks apart → one y_valid only, at first+12; overrun_err=1 and stays 1 until reset.
- Reset mid-MAC: assert reset at T+5 → no y_valid at T+12, y=0, busy=0. A subsequent impulse test then passes.

Source files
------------

// File: rtl/downsampler_pkg.sv
// Shared constants for the matched polyphase filter pair (downsampler/upsampler).
// Holds the tap count, the 10 unique coefficients of the 20-tap symmetric
// root/low-pass filter (1s17), datapath widths, output slice positions, the
// FSM state encodings and the accumulator-to-output saturation helper.
package downsampler_pkg;

    localparam int N_TAPS    = 20;
    localparam int HALF_TAPS = N_TAPS / 2;
    localparam int SAMPLE_W  = 18;
    localparam int PRE_W     = 19;
    localparam int PROD_W    = 37;
    localparam int ACC_W     = 40;
    localparam int OUT_HI    = 34;
    localparam int OUT_LO    = 17;

    localparam logic [3:0] LAST_K = 4'd9;

    // Unique half of the symmetric impulse response; b[19-k] = b[k].
    localparam logic signed [SAMPLE_W-1:0] COEF [0:HALF_TAPS-1] = '{
        18'sd599,   18'sd764,   -18'sd30,   -18'sd2078, -18'sd4101,
        -18'sd3432, 18'sd2323,  18'sd13046, 18'sd25177, 18'sd33269
    };

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_MAC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Floor-truncate acc to 1s17; clamp when the bits above the slice disagree with the sign.
    function automatic logic signed [SAMPLE_W-1:0] sat_acc(input logic signed [ACC_W-1:0] a);
        logic signed [SAMPLE_W-1:0] r;
        if (a[ACC_W-1:OUT_HI] == {(ACC_W-OUT_HI){a[ACC_W-1]}}) begin
            r = a[OUT_HI:OUT_LO];
        end else if (a[ACC_W-1]) begin
            r = 18'sh20000;
        end else begin
            r = 18'sh1FFFF;
        end
        return r;
    endfunction

endpackage

// File: rtl/downsampler_if.sv
// Sample/symbol interface of the downsampler.
// master: drives strobes and x_in, observes the filtered output.
// slave : the filter itself.
interface downsampler_if;
    import downsampler_pkg::*;

    logic                       sam_clk_ena;
    logic                       sym_clk_ena;
    logic signed [SAMPLE_W-1:0] x_in;
    logic signed [SAMPLE_W-1:0] y;
    logic                       y_valid;
    logic                       busy;
    logic                       overrun_err;

    modport master (
        output sam_clk_ena, sym_clk_ena, x_in,
        input  y, y_valid, busy, overrun_err
    );

    modport slave (
        input  sam_clk_ena, sym_clk_ena, x_in,
        output y, y_valid, busy, overrun_err
    );

endinterface

// File: rtl/sym_mac.sv
// Folded pre-add / multiply / accumulate datapath of the decimating filter.
// Ports: clk, reset (sync, active-high); clear zeroes acc; enable adds one
// tap term coef*(s_a+s_b); y_sat is the saturated 1s17 value the accumulator
// will hold after the current term, so the caller can latch the result on
// the last tap without an extra cycle.
module sym_mac
    import downsampler_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] s_a,
    input  logic signed [SAMPLE_W-1:0] s_b,
    input  logic signed [SAMPLE_W-1:0] coef,
    output logic signed [SAMPLE_W-1:0] y_sat
);

    logic signed [PRE_W-1:0]  pre_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  acc_next_s;
    logic signed [ACC_W-1:0]  acc_r;

    // Pre-add of the symmetric pair, product and running sum.
    always_comb begin
        pre_s      = {s_a[SAMPLE_W-1], s_a} + {s_b[SAMPLE_W-1], s_b};
        prod_s     = $signed({{(PROD_W-PRE_W){pre_s[PRE_W-1]}}, pre_s})
                   * $signed({{(PROD_W-SAMPLE_W){coef[SAMPLE_W-1]}}, coef});
        acc_next_s = acc_r + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        y_sat      = sat_acc(acc_next_s);
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= 40'sd0;
        end else if (clear) begin
            acc_r <= 40'sd0;
        end else if (enable) begin
            acc_r <= acc_next_s;
        end
    end

endmodule

// File: rtl/downsampler.sv
// Receive-side 4:1 polyphase decimating matched filter.
// Ports: clk, reset (sync, active-high), bus (downsampler_if.slave):
//   sam_clk_ena/x_in shift a sample into the 20-deep window, sym_clk_ena
//   starts one output; y/y_valid deliver it 12 clocks later, busy covers the
//   computation, overrun_err is sticky for triggers that arrive while busy.
module downsampler
    import downsampler_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    downsampler_if.slave bus
);

    logic signed [SAMPLE_W-1:0] window_r [0:N_TAPS-1];
    logic signed [SAMPLE_W-1:0] snap_r   [0:N_TAPS-1];
    logic [1:0]                 state_r;
    logic [1:0]                 state_next_s;
    logic [3:0]                 k_r;
    logic [4:0]                 idx_lo_s;
    logic [4:0]                 idx_hi_s;
    logic                       last_tap_s;
    logic signed [SAMPLE_W-1:0] y_sat_s;
    logic signed [SAMPLE_W-1:0] y_r;
    logic                       y_valid_r;
    logic                       busy_r;
    logic                       overrun_r;

    assign last_tap_s = (state_r == ST_MAC) && (k_r == LAST_K);
    assign idx_lo_s   = {1'b0, k_r};
    assign idx_hi_s   = 5'd19 - idx_lo_s;

    // Next-state decode of the control FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.sym_clk_ena) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: state_next_s = ST_MAC;
            ST_MAC: begin
                if (last_tap_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MAC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Sample window: newest sample at index 0, keeps shifting during MAC.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) window_r[i] <= 18'sd0;
        end else if (bus.sam_clk_ena) begin
            window_r[0] <= bus.x_in;
            for (int i = 1; i < N_TAPS; i++) window_r[i] <= window_r[i-1];
        end
    end

    // Snapshot taken in LOAD; it already contains a sample coincident with the trigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) snap_r[i] <= 18'sd0;
        end else if (state_r == ST_LOAD) begin
            for (int i = 0; i < N_TAPS; i++) snap_r[i] <= window_r[i];
        end
    end

    // FSM state and tap index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            k_r     <= 4'd0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_LOAD) begin
                k_r <= 4'd0;
            end else if (state_r == ST_MAC) begin
                k_r <= k_r + 4'd1;
            end
        end
    end

    // Registered outputs; y is latched on the last tap so it and y_valid appear together in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_r       <= 18'sd0;
            y_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (last_tap_s) begin
                y_r <= y_sat_s;
            end
            y_valid_r <= last_tap_s;
            busy_r    <= (state_next_s != ST_IDLE);
            if (bus.sym_clk_ena && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    sym_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_r == ST_LOAD),
        .enable (state_r == ST_MAC),
        .s_a    (snap_r[idx_lo_s]),
        .s_b    (snap_r[idx_hi_s]),
        .coef   (COEF[k_r]),
        .y_sat  (y_sat_s)
    );

    assign bus.y           = y_r;
    assign bus.y_valid     = y_valid_r;
    assign bus.busy        = busy_r;
    assign bus.overrun_err = overrun_r;

endmodule
